// File: rtl/spi_slave_bit_engine.sv
// SPI responder bit engine, oversampling sclk/cs_n/din in the clk domain.
// Optional SPI_SLV_OVERRUN_EN adds an overrun flag for frames longer than MAX_BITS.
module spi_slave_bit_engine #(
   parameter int MAX_BITS    = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [MAX_BITS-1:0] tx_bits,
   input  logic                sclk,
   input  logic                cs_n,
   input  logic                din,
   output logic                dout,
   output logic [MAX_BITS-1:0] rx_bits,
   output logic [15:0]         rx_count,
   output logic                rx_valid,
`ifdef SPI_SLV_OVERRUN_EN
   output logic                overrun,
`endif
   output logic                busy
);

   localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam logic [15:0] MAX_N = 16'(MAX_BITS);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
   logic sclk_d, cs_d;
   logic sclk_s, cs_s, din_s;
   logic cpol_q, cpha_q;
   logic [MAX_BITS-1:0] tx_q, rx_shift;
   logic [15:0] n, tx_idx;
`ifdef SPI_SLV_OVERRUN_EN
   logic [15:0] samples;
`endif

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign din_s  = din_sync[SYNC_STAGES-1];

   logic cs_fall, cs_rise, sclk_edge, lead, trail, smp, shf;
   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_edge = sclk_s ^ sclk_d;
   assign lead      = sclk_edge & (sclk_s != cpol_q);
   assign trail     = sclk_edge & (sclk_s == cpol_q);
   assign smp       = cpha_q ? trail : lead;
   assign shf       = cpha_q ? lead : trail;

   // Sync chains reset low so a frame in flight across reset is never re-detected
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         din_sync  <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_rise) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         tx_q     <= '0;
         rx_shift <= '0;
         n        <= '0;
         tx_idx   <= '0;
         dout     <= 1'b0;
         rx_bits  <= '0;
         rx_count <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
         samples  <= '0;
         overrun  <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         unique case (state_q)
            IDLE: begin
               dout <= 1'b0;
               if (cs_fall) begin
                  cpol_q   <= cpol;
                  cpha_q   <= cpha;
                  tx_q     <= tx_bits;
                  rx_shift <= '0;
                  n        <= '0;
                  busy     <= 1'b1;
                  dout     <= cpha ? 1'b0 : tx_bits[0];
                  tx_idx   <= cpha ? 16'd0 : 16'd1;
`ifdef SPI_SLV_OVERRUN_EN
                  samples  <= '0;
`endif
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  rx_bits  <= rx_shift;
                  rx_count <= n;
                  rx_valid <= 1'b1;
                  busy     <= 1'b0;
                  dout     <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
                  overrun  <= (samples > MAX_N);
`endif
               end else begin
                  if (smp) begin
                     if (n < MAX_N) begin
                        rx_shift[n[IW-1:0]] <= din_s;
                        n <= n + 16'd1;
                     end
`ifdef SPI_SLV_OVERRUN_EN
                     if (samples != 16'hFFFF) samples <= samples + 16'd1;
`endif
                  end
                  if (shf) begin
                     if (tx_idx < MAX_N) begin
                        dout   <= tx_q[tx_idx[IW-1:0]];
                        tx_idx <= tx_idx + 16'd1;
                     end else begin
                        dout <= 1'b0;
                     end
                  end
               end
            end
            DONE:    dout <= 1'b0;
            default: dout <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/spi_slave_bit_engine.md
Name: spi_slave_bit_engine

Overview:
- Responder end of the SPI bit engine: an SPI/AWMF-style slave that runs in the system clock domain and oversamples sclk, cs_n and din.
- Receives one variable-length frame into a MAX_BITS vector and shifts a preloaded MAX_BITS vector out on dout.
- Used as the device-side model and loopback partner for the master engine in XSIM benches. Also usable as a synthesizable slave in FPGA-to-FPGA links.

Parameters:
- MAX_BITS, 100, width of tx_bits/rx_bits and maximum stored frame length.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/din (legal values: 2 or 3).

Ports:
- clk  input  1  system clock; every flop is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpol  input  1  clock idle level; captured at frame start.
- cpha  input  1  0 = sample on the leading edge, 1 = sample on the trailing edge; captured at frame start.
- tx_bits  input  MAX_BITS  data to return; captured at frame start.
- sclk  input  1  SPI clock from the master (asynchronous to clk).
- cs_n  input  1  active-low chip select from the master (asynchronous).
- din  input  1  serial data in (mosi / sdi / pdi).
- dout  output  1  serial data out (miso / sdo).
- rx_bits  output  MAX_BITS  last completed frame; rx_bits[k] is the k-th bit received.
- rx_count  output  16  number of bits received in the last frame, saturating at MAX_BITS.
- rx_valid  output  1  one-clk pulse when rx_bits/rx_count update.
- busy  output  1  high while a frame is active.

Behaviour:
- Input synchronization: sclk, cs_n and din each pass through a SYNC_STAGES flop chain. Edges are detected by comparing the last synchronized sample with the previous one.
- Oversampling requirement: each sclk half-period and the cs_n setup/hold time must be at least 4 clk cycles.
- Reset values: dout=0, rx_bits=0, rx_count=0, rx_valid=0, busy=0, state=IDLE, internal shift/counter registers=0.
- Leading edge is the sclk transition away from cpol; trailing edge is the transition back to cpol.
- IDLE:
  - On a synchronized cs_n falling edge: capture cpol, cpha and tx_bits; clear the bit counter and rx shift register; go to ACTIVE.
  - Assert busy on the following cycle.
  - If cpha=0, drive dout=tx_bits[0] in the same cycle busy rises (first bit presented before the first leading edge).
- ACTIVE:
  - Sample din on the leading edge (cpha=0) or trailing edge (cpha=1).
  - The bit at index n goes to rx_shift[n]. n increments per sample and saturates at MAX_BITS. Samples with n≥MAX_BITS are discarded.
  - Shift dout on the opposite edge (trailing for cpha=0, leading for cpha=1), advancing to the next tx_bits index.
  - Once the index reaches or exceeds MAX_BITS, dout=0.
- ACTIVE → DONE on a synchronized cs_n rising edge at any point, including mid-bit (an aborted or partial frame is still reported).
- DONE, for one cycle:
  - rx_bits←rx_shift, rx_count←n, rx_valid=1.
  - busy=0, dout=0.
  - Return to IDLE.
- rx_bits/rx_count hold their values between frames. Unreceived high bits of rx_bits are 0.
- An sclk edge in the same cycle as the cs_n rising edge is ignored; the cs_n edge wins.
- A frame with zero clocks gives rx_count=0, rx_bits=0, and rx_valid still pulses.
- dout=0 whenever state≠ACTIVE. No tri-state.
- Changes to cpol/cpha/tx_bits during ACTIVE have no effect until the next frame.
- Asserting rst mid-frame forces the reset values immediately. A frame already in progress on the wire is not reported. A new frame is only recognised after the next cs_n falling edge.
- The master's bit_count field has no equivalent here; the slave sizes each frame by counting sclk edges.

Optional Feature:
- Macro SPI_SLV_OVERRUN_EN.
- When defined:
  - Adds output `overrun` (1 bit), reset 0, updated together with rx_bits in DONE.
  - overrun=1 if more than MAX_BITS samples occurred in the frame; rx_count still saturates at MAX_BITS.
  - Adds an internal 16-bit unsaturated sample counter, which itself saturates at 16'hFFFF.
- When undefined: the port and counter are absent; excess bits are silently dropped.

Test Plan:
- Mode 0 (cpol=0, cpha=0), 8-bit frame, master sends din bits 1,0,1,1,0,0,1,0, tx_bits[7:0]=8'h3C → rx_bits[7:0]=8'b01001101, rx_count=8, one rx_valid pulse, master reads back 0,0,1,1,1,1,0,0.
- Mode 3 (cpol=1, cpha=1), 100-bit frame against the master engine with a random 100-bit pattern both ways → both ends receive the exact vector, rx_count=100.
- 120-bit frame with MAX_BITS=100 → rx_count=100, bits 100..119 dropped, dout=0 for bits 100..119; with SPI_SLV_OVERRUN_EN, overrun=1.
- cs_n deasserted after 5 bits in mode 1 → rx_count=5, rx_bits[4:0] correct, rx_bits[99:5]=0, rx_valid pulses, busy falls.
- rst asserted at bit 40 of a 64-bit frame, released, then an 8-bit frame → no rx_valid for the aborted frame; the 8-bit frame is reported correctly with rx_count=8.
- Back-to-back frames with cs_n high for 4 clk: frame 1 tx_bits=…A5, frame 2 tx_bits=…5A → each returns its own data, two rx_valid pulses.
